// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port integer register file with post-reset init sweep.
// Registered reads per port, write-to-read forwarding, ready gates fetch start.
//
// Ports:
//   clk     in   clock, all state on rising edge
//   resetn  in   synchronous active-low reset
//   ready   out  high once every register holds its init value
//   we      in   write enable
//   A3      in   write address
//   wd      in   write data
//   re      in   per-port read enable
//   ra      in   packed read addresses, 5 bits per port
//   rd      out  packed registered read data, XLEN bits per port
module register_file_mp #(
  parameter int XLEN           = 32,
  parameter int REGISTER_DEPTH = 32,
  parameter int READ_PORTS     = 2,
  parameter logic [XLEN-1:0] STACKADDR = 'hffff_ffff,
  parameter logic [XLEN-1:0] HARTID    = '0,
  parameter logic [XLEN-1:0] DTB_ADDR  = 'h81ff_f800
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       ready,
  input  logic                       we,
  input  logic [4:0]                 A3,
  input  logic [XLEN-1:0]            wd,
  input  logic [READ_PORTS-1:0]      re,
  input  logic [5*READ_PORTS-1:0]    ra,
  output logic [XLEN*READ_PORTS-1:0] rd
);

  localparam int AW = $clog2(REGISTER_DEPTH);
  localparam logic [5:0] DEPTH6 = 6'(REGISTER_DEPTH);
  localparam logic [4:0] LAST = 5'(REGISTER_DEPTH - 1);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic            state;
  logic [4:0]      cnt;
  logic [XLEN-1:0] bank [REGISTER_DEPTH];
  logic [XLEN-1:0] init_val;
  logic            wr_ok;
  logic [XLEN-1:0] rd_q [READ_PORTS];

  always_comb begin
    init_val = '0;
    if (cnt == 5'd2)
      init_val = STACKADDR;
    else if (cnt == 5'd10)
      init_val = HARTID;
    else if (cnt == 5'd11)
      init_val = DTB_ADDR;
  end

  // x0 and addresses beyond the bank are dropped
  assign wr_ok = (state == ST_RUN) && we &&
                 (A3 != 5'd0) &&
                 ({1'b0, A3} < DEPTH6);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 5'd1;
      if (cnt == LAST) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end
    end
  end

  // bank is deliberately left alone at the reset edge
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == ST_INIT)
        bank[cnt[AW-1:0]] <= init_val;
      else if (wr_ok)
        bank[A3[AW-1:0]] <= wd;
    end
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic [4:0] a;
    logic       a_ok;

    assign a    = ra[5*i +: 5];
    assign a_ok = (a != 5'd0) && ({1'b0, a} < DEPTH6);

    always_ff @(posedge clk) begin
      if (!resetn) begin
        rd_q[i] <= '0;
      end else if (state == ST_RUN && re[i]) begin
        if (!a_ok)
          rd_q[i] <= '0;
        else if (wr_ok && A3 == a)
          rd_q[i] <= wd;
        else
          rd_q[i] <= bank[a[AW-1:0]];
      end
    end

    assign rd[XLEN*i +: XLEN] = rd_q[i];
  end

endmodule
